jk_bank_ctrl: RTL and testbench
===============================

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of JK flip-flops in the controlled bank.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-006 SHALL have port cmd_op  input  3  operation code (see REQ-011).
REQ-007 SHALL have port cmd_data  input  WIDTH  load value or step count.
REQ-008 SHALL have port q  output  WIDTH  bank state.
REQ-009 SHALL have port qb  output  WIDTH  bitwise complement of q, at all times.
REQ-010 SHALL have ports done and err  output  1 each  one-cycle completion and illegal-op pulses.

Function
REQ-011 SHALL decode cmd_op: 000 HOLD (J=K=0); 001 LOAD (J=d, K=~d); 010 CLEAR (J=0, K=1); 011 SET (J=1, K=0); 100 TOGGLE (J=K=1); 101 COUNT; 110 ROTATE; 111 illegal.
REQ-012 SHALL drive q exclusively through per-bit J/K inputs of the bank; no direct register load of q.
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE; cmd_ready=1 only in IDLE with rst low.
REQ-014 SHALL accept on an edge where cmd_valid and cmd_ready are both 1, latch cmd_op/cmd_data and enter EXEC.
REQ-015 SHALL, for HOLD/LOAD/CLEAR/SET/TOGGLE, apply J/K during the single EXEC cycle: q updates on the edge after acceptance (latency 1), then DONE.
REQ-016 SHALL, for COUNT, step q up by one per EXEC cycle via synchronous JK counting (J_i=K_i=AND of q[i-1:0]) for k=cmd_data steps, where k=0 means 2^WIDTH steps.
REQ-017 SHALL wrap COUNT from all-ones to zero without stalling or flagging.
REQ-018 SHALL, for ROTATE, rotate q left one bit per EXEC cycle for cmd_data[1:0]+1 steps (1..4), using J=q[i-1], K=~q[i-1].
REQ-019 SHALL hold a step counter, decrement it each EXEC cycle, and leave EXEC for DONE on the edge where the final step is applied.
REQ-020 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-021 SHALL, for op 111, leave q unchanged, assert err together with done in DONE, and return to IDLE.
REQ-022 SHALL ignore cmd_valid while not in IDLE; inputs are not sampled after acceptance.
REQ-023 SHALL drive J=K=0 (hold) on every bit in IDLE and DONE.

Reset
REQ-024 SHALL, on an edge with rst=1, set q=0, qb=all-ones, state=IDLE, step counter=0, done=0, err=0.
REQ-025 SHALL force cmd_ready=0 while rst=1.
REQ-026 SHALL abort any EXEC operation on reset with no done/err pulse; partial q results are discarded by REQ-024.

Structure
REQ-027 SHALL place the op encodings, FSM state encoding and default WIDTH in shared package ff_ctrl_pkg.
REQ-028 SHALL instantiate WIDTH copies of sub-module jk_cell (JK flip-flop, clk, synchronous active-high rst, outputs q/qb).

Verification
REQ-029 SHALL cover: reset, then LOAD with cmd_data=1010 accepted at edge N -> q=1010, qb=0101 after edge N+1; done=1 for one cycle; cmd_ready=1 again after edge N+2.
REQ-030 SHALL cover: q=1110, COUNT with cmd_data=0011 -> q sequence 1111, 0000, 0001; done after the third step; cmd_ready=0 throughout.
REQ-031 SHALL cover: q=0001, ROTATE with cmd_data=0010 -> q sequence 0010, 0100, 1000; single done pulse.
REQ-032 SHALL cover: q=0110, SET, TOGGLE, CLEAR back-to-back with cmd_valid held high -> q 1111, 0000, 0000; each accepted only in IDLE.
REQ-033 SHALL cover: op 111 with q=0101 -> q stays 0101; err and done are high together for one cycle.
REQ-034 SHALL cover: COUNT with cmd_data=0000 from 0000 and rst asserted after 5 steps -> q=0000 on the reset edge; no done; cmd_ready=1 the cycle after rst drops.

Source files
------------

// File: rtl/ff_ctrl_pkg.sv
// Shared definitions for the JK bank controller: op codes, FSM states and
// default bank width.
package ff_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_HOLD    = 3'b000,
        OP_LOAD    = 3'b001,
        OP_CLEAR   = 3'b010,
        OP_SET     = 3'b011,
        OP_TOGGLE  = 3'b100,
        OP_COUNT   = 3'b101,
        OP_ROTATE  = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset and complementary output.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   state_q <= 1'b0;
                2'b10:   state_q <= 1'b1;
                2'b11:   state_q <= ~state_q;
                default: state_q <= state_q;
            endcase
        end
    end

    assign q  = state_q;
    assign qb = ~state_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command-driven controller for a bank of JK flip-flops; every change to q is
// made through the per-bit J/K inputs of the cells. WIDTH must be at least 2.
module jk_bank_ctrl
    import ff_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             done,
    output logic             err
);

    localparam int CW = WIDTH + 1;

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    stepCnt_q;
    logic             done_q;
    logic             err_q;

    logic [CW-1:0]    startSteps;
    logic [WIDTH-1:0] jBank;
    logic [WIDTH-1:0] kBank;
    logic [WIDTH-1:0] qBank;
    logic [WIDTH-1:0] qbBank;
    logic             carry;

    // A COUNT of zero means one full wrap of the bank, hence the extra counter bit.
    always_comb begin
        startSteps = CW'(1);
        case (op_e'(cmd_op))
            OP_COUNT:  startSteps = (cmd_data == '0) ? (CW'(1) << WIDTH) : CW'(cmd_data);
            OP_ROTATE: startSteps = CW'(cmd_data[1:0]) + CW'(1);
            default:   startSteps = CW'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_HOLD;
            data_q    <= '0;
            stepCnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (cmd_valid) begin
                        op_q      <= op_e'(cmd_op);
                        data_q    <= cmd_data;
                        stepCnt_q <= startSteps;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    stepCnt_q <= stepCnt_q - CW'(1);
                    if (stepCnt_q == CW'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= (op_q == OP_ILLEGAL);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outside EXEC every cell sees J=K=0 and holds its value.
    always_comb begin
        jBank = '0;
        kBank = '0;
        carry = 1'b1;
        if (state_q == EXEC) begin
            case (op_q)
                OP_LOAD: begin
                    jBank = data_q;
                    kBank = ~data_q;
                end
                OP_CLEAR:  kBank = '1;
                OP_SET:    jBank = '1;
                OP_TOGGLE: begin
                    jBank = '1;
                    kBank = '1;
                end
                OP_COUNT: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        jBank[i] = carry;
                        kBank[i] = carry;
                        carry    = carry & qBank[i];
                    end
                end
                OP_ROTATE: begin
                    jBank = {qBank[WIDTH-2:0], qBank[WIDTH-1]};
                    kBank = ~{qBank[WIDTH-2:0], qBank[WIDTH-1]};
                end
                default: begin
                    jBank = '0;
                    kBank = '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (jBank[i]),
            .k   (kBank[i]),
            .q   (qBank[i]),
            .qb  (qbBank[i])
        );
    end

    assign q         = qBank;
    assign qb        = qbBank;
    assign done      = done_q;
    assign err       = err_q;
    assign cmd_ready = (state_q == IDLE) && !rst;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl: hand-computed q/qb/handshake values for each
// command type, back-to-back acceptance, illegal op and reset abort.
module tb_jk_bank_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         done;
    logic         err;

    int checkCount = 0;
    int errorCount = 0;

    jk_bank_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .q         (q),
        .qb        (qb),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns 1ns after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] data);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        #1;
        checkOutput("ready_before_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for the done pulse, then one more falling edge so the DUT is back in IDLE.
    task automatic waitDone();
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic doCmd(input logic [2:0] op, input logic [W-1:0] data);
        applyStimulus(op, data);
        waitDone();
    endtask

    initial begin
        logic [W-1:0] expSeq [3];
        logic [2:0]   b2bOps [3];
        logic [W-1:0] b2bExp [3];

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_q", 32'(q), 32'h0);
        checkOutput("rst_qb", 32'(qb), 32'hF);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1 checkOutput("ready_after_rst", 32'(cmd_ready), 32'd1);

        // LOAD 1010: latency one edge, single done, ready after the next edge
        applyStimulus(3'b001, 4'b1010);
        @(negedge clk);
        checkOutput("load_exec_q", 32'(q), 32'h0);
        checkOutput("load_exec_ready", 32'(cmd_ready), 32'd0);
        checkOutput("load_exec_done", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("load_q", 32'(q), 32'hA);
        checkOutput("load_qb", 32'(qb), 32'h5);
        checkOutput("load_done", 32'(done), 32'd1);
        checkOutput("load_err", 32'(err), 32'd0);
        checkOutput("load_done_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        checkOutput("load_done_drop", 32'(done), 32'd0);
        checkOutput("load_ready_again", 32'(cmd_ready), 32'd1);

        // HOLD leaves q alone
        doCmd(3'b000, 4'b0101);
        checkOutput("hold_q", 32'(q), 32'hA);

        // COUNT 3 from 1110 wraps through all-ones to zero
        doCmd(3'b001, 4'b1110);
        checkOutput("pre_count_q", 32'(q), 32'hE);
        expSeq = '{4'b1111, 4'b0000, 4'b0001};
        applyStimulus(3'b101, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("count_q_%0d", i), 32'(q), 32'(expSeq[i]));
            checkOutput($sformatf("count_done_%0d", i), 32'(done), (i == 2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("count_ready_%0d", i), 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        checkOutput("count_done_drop", 32'(done), 32'd0);
        checkOutput("count_ready_again", 32'(cmd_ready), 32'd1);

        // ROTATE 3 steps from 0001
        doCmd(3'b001, 4'b0001);
        expSeq = '{4'b0010, 4'b0100, 4'b1000};
        applyStimulus(3'b110, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("rot_q_%0d", i), 32'(q), 32'(expSeq[i]));
            checkOutput($sformatf("rot_done_%0d", i), 32'(done), (i == 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        checkOutput("rot_done_drop", 32'(done), 32'd0);
        checkOutput("rot_q_final", 32'(q), 32'h8);

        // SET, TOGGLE, CLEAR with cmd_valid held; op changes mid-EXEC must be ignored
        doCmd(3'b001, 4'b0110);
        b2bOps = '{3'b011, 3'b100, 3'b010};
        b2bExp = '{4'b1111, 4'b0000, 4'b0000};
        cmd_op    = b2bOps[0];
        cmd_data  = 4'b0000;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput($sformatf("b2b_ready_idle_%0d", i), 32'(cmd_ready), 32'd1);
            @(negedge clk);
            checkOutput($sformatf("b2b_ready_exec_%0d", i), 32'(cmd_ready), 32'd0);
            if (i < 2) cmd_op = b2bOps[i+1];
            else cmd_valid = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("b2b_q_%0d", i), 32'(q), 32'(b2bExp[i]));
            checkOutput($sformatf("b2b_done_%0d", i), 32'(done), 32'd1);
            checkOutput($sformatf("b2b_ready_done_%0d", i), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("b2b_ready_end", 32'(cmd_ready), 32'd1);
        checkOutput("b2b_q_end", 32'(q), 32'h0);

        // Illegal op keeps q and pulses err with done
        doCmd(3'b001, 4'b0101);
        applyStimulus(3'b111, 4'b1111);
        @(negedge clk);
        checkOutput("ill_exec_err", 32'(err), 32'd0);
        @(negedge clk);
        checkOutput("ill_q", 32'(q), 32'h5);
        checkOutput("ill_done", 32'(done), 32'd1);
        checkOutput("ill_err", 32'(err), 32'd1);
        @(negedge clk);
        checkOutput("ill_done_drop", 32'(done), 32'd0);
        checkOutput("ill_err_drop", 32'(err), 32'd0);
        checkOutput("ill_ready", 32'(cmd_ready), 32'd1);

        // COUNT 0 (16 steps) aborted by reset after 5 steps
        doCmd(3'b010, 4'b0000);
        applyStimulus(3'b101, 4'b0000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_q_5", 32'(q), 32'h5);
        checkOutput("abort_done_5", 32'(done), 32'd0);
        rst = 1'b1;
        #1 checkOutput("abort_ready_in_rst", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        checkOutput("abort_q", 32'(q), 32'h0);
        checkOutput("abort_qb", 32'(qb), 32'hF);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1 checkOutput("abort_ready_after", 32'(cmd_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'(done), 32'd0);
            checkOutput("abort_q_hold", 32'(q), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
